// File: rtl/mem_access_ctrl.sv
// ============================================================================
// mem_access_ctrl : MEM-stage load/store controller with bus handshake,
//                   lane steering, extension, alignment check, MEM/WB register
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_en,
  input  logic [3:0]  ex_exp_code,
  input  logic [31:0] ex_pc,
  input  logic [3:0]  ex_mem_op,
  input  logic [31:0] ex_mem_wr_data,
  input  logic [31:0] ex_out,
  input  logic [4:0]  ex_rd_addr,
  input  logic        ex_gpr_we_,
  input  logic [1:0]  ex_hart_st,
  output logic        dbus_rq,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wr_data,
  input  logic        dbus_rdy,
  input  logic [31:0] dbus_rd_data,
  output logic        busy,
  output logic        mem_en,
  output logic [3:0]  mem_exp_code,
  output logic [31:0] mem_pc,
  output logic [31:0] mem_out,
  output logic [4:0]  mem_rd_addr,
  output logic        mem_gpr_we_,
  output logic [1:0]  mem_hart_st
);

  localparam logic       ENABLE       = 1'b1;
  localparam logic       DISABLE      = 1'b0;
  localparam logic       DISABLE_     = 1'b1;
  localparam logic [3:0] EXP_NO_EXP   = 4'h0;
  localparam logic [3:0] EXP_MISALIGN = 4'h3;

  localparam logic [3:0] MEM_OP_NOP  = 4'd0;
  localparam logic [3:0] MEM_OP_LDW  = 4'd1;
  localparam logic [3:0] MEM_OP_LDH  = 4'd2;
  localparam logic [3:0] MEM_OP_LDHU = 4'd3;
  localparam logic [3:0] MEM_OP_LDB  = 4'd4;
  localparam logic [3:0] MEM_OP_LDBU = 4'd5;
  localparam logic [3:0] MEM_OP_STW  = 4'd6;
  localparam logic [3:0] MEM_OP_STH  = 4'd7;
  localparam logic [3:0] MEM_OP_STB  = 4'd8;

  // HOLD keeps a completed load result while the hart controller stalls us
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state, next_state;
  logic        kill;
  logic [1:0]  lane_off;
  logic [31:0] load_buf;

  logic        is_word, is_half, is_byte, is_store, is_load, is_mem;
  logic        misalign, checked, access_needed, misaligned;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] load_fmt;
  logic [31:0] load_val;
  logic [31:0] out_val;

  assign is_word  = (ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW);
  assign is_half  = (ex_mem_op == MEM_OP_LDH) || (ex_mem_op == MEM_OP_LDHU) ||
                    (ex_mem_op == MEM_OP_STH);
  assign is_byte  = (ex_mem_op == MEM_OP_LDB) || (ex_mem_op == MEM_OP_LDBU) ||
                    (ex_mem_op == MEM_OP_STB);
  assign is_store = (ex_mem_op == MEM_OP_STW) || (ex_mem_op == MEM_OP_STH) ||
                    (ex_mem_op == MEM_OP_STB);
  assign is_load  = (is_word || is_half || is_byte) && !is_store;
  assign is_mem   = is_load || is_store;

  assign misalign      = (is_word && (ex_out[1:0] != 2'b00)) || (is_half && ex_out[0]);
  assign checked       = (ex_en == ENABLE) && (ex_exp_code == EXP_NO_EXP) && is_mem;
  assign access_needed = checked && !misalign;
  assign misaligned    = checked && misalign;

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = ex_mem_wr_data;
    if (is_byte) begin
      be_calc    = 4'b0001 << ex_out[1:0];
      wdata_calc = {4{ex_mem_wr_data[7:0]}};
    end else if (is_half) begin
      be_calc    = ex_out[1] ? 4'b1100 : 4'b0011;
      wdata_calc = {2{ex_mem_wr_data[15:0]}};
    end
  end

  // Lane select uses the offset latched at issue, not the live EX address
  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = dbus_rd_data[{lane_off, 3'b000} +: 8];
    h = lane_off[1] ? dbus_rd_data[31:16] : dbus_rd_data[15:0];
    case (ex_mem_op)
      MEM_OP_LDB:  load_fmt = {{24{b[7]}}, b};
      MEM_OP_LDBU: load_fmt = {24'h0, b};
      MEM_OP_LDH:  load_fmt = {{16{h[15]}}, h};
      MEM_OP_LDHU: load_fmt = {16'h0, h};
      default:     load_fmt = dbus_rd_data;
    endcase
  end

  assign load_val = (state == ST_HOLD) ? load_buf : load_fmt;
  assign out_val  = (access_needed && is_load) ? load_val : ex_out;

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = access_needed;
        if (access_needed && !flush) next_state = ST_BUSY;
      end
      ST_BUSY: begin
        busy = !dbus_rdy;
        if (dbus_rdy) next_state = stall ? ST_HOLD : ST_IDLE;
      end
      ST_HOLD: begin
        busy = stall;
        if (!stall) next_state = ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      kill         <= 1'b0;
      dbus_rq      <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_be      <= 4'b0000;
      dbus_addr    <= 32'h0;
      dbus_wr_data <= 32'h0;
      lane_off     <= 2'b00;
      load_buf     <= 32'h0;
    end else begin
      state <= next_state;
      if (state == ST_IDLE) begin
        if (access_needed && !flush) begin
          dbus_rq      <= 1'b1;
          dbus_we      <= is_store;
          dbus_be      <= be_calc;
          dbus_addr    <= {ex_out[31:2], 2'b00};
          dbus_wr_data <= wdata_calc;
          lane_off     <= ex_out[1:0];
        end
      end else begin
        if (next_state == ST_IDLE) kill <= 1'b0;
        else if (flush)            kill <= 1'b1;
      end
      if (state == ST_BUSY && dbus_rdy) begin
        dbus_rq  <= 1'b0;
        load_buf <= load_fmt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_en       <= DISABLE;
      mem_exp_code <= EXP_NO_EXP;
      mem_pc       <= 32'h0;
      mem_out      <= 32'h0;
      mem_rd_addr  <= 5'd0;
      mem_gpr_we_  <= DISABLE_;
      mem_hart_st  <= 2'd0;
    end else if (!stall) begin
      if (flush || busy || kill) begin
        mem_en       <= DISABLE;
        mem_exp_code <= EXP_NO_EXP;
        mem_pc       <= 32'h0;
        mem_out      <= 32'h0;
        mem_rd_addr  <= 5'd0;
        mem_gpr_we_  <= DISABLE_;
        mem_hart_st  <= 2'd0;
      end else begin
        mem_en       <= ex_en;
        mem_exp_code <= misaligned ? EXP_MISALIGN : ex_exp_code;
        mem_pc       <= ex_pc;
        mem_out      <= out_val;
        mem_rd_addr  <= ex_rd_addr;
        mem_gpr_we_  <= (misaligned || (checked && is_store)) ? DISABLE_ : ex_gpr_we_;
        mem_hart_st  <= ex_hart_st;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table for single-cycle behaviour,
// hand-written sequences for bus transactions.
`default_nettype none

module tb_mem_access_ctrl;

  localparam logic [3:0] NOP = 4'd0, LDW = 4'd1, LDH = 4'd2, LDHU = 4'd3, LDB = 4'd4,
                         LDBU = 4'd5, STW = 4'd6, STH = 4'd7, STB = 4'd8;
  localparam logic [3:0] MIS = 4'h3, ILL = 4'h2;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic        ex_en;
  logic [3:0]  ex_exp_code, ex_mem_op;
  logic [31:0] ex_pc, ex_mem_wr_data, ex_out;
  logic [4:0]  ex_rd_addr;
  logic        ex_gpr_we_;
  logic [1:0]  ex_hart_st;
  logic        dbus_rq, dbus_we, dbus_rdy;
  logic [31:0] dbus_addr, dbus_wr_data, dbus_rd_data;
  logic [3:0]  dbus_be;
  logic        busy, mem_en, mem_gpr_we_;
  logic [3:0]  mem_exp_code;
  logic [31:0] mem_pc, mem_out;
  logic [4:0]  mem_rd_addr;
  logic [1:0]  mem_hart_st;

  int nvec = 0;
  int nerr = 0;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_en(ex_en), .ex_exp_code(ex_exp_code), .ex_pc(ex_pc), .ex_mem_op(ex_mem_op),
    .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out), .ex_rd_addr(ex_rd_addr),
    .ex_gpr_we_(ex_gpr_we_), .ex_hart_st(ex_hart_st),
    .dbus_rq(dbus_rq), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
    .dbus_wr_data(dbus_wr_data), .dbus_rdy(dbus_rdy), .dbus_rd_data(dbus_rd_data),
    .busy(busy), .mem_en(mem_en), .mem_exp_code(mem_exp_code), .mem_pc(mem_pc),
    .mem_out(mem_out), .mem_rd_addr(mem_rd_addr), .mem_gpr_we_(mem_gpr_we_),
    .mem_hart_st(mem_hart_st)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        flush, stall, en;
    logic [3:0]  exp, op;
    logic [31:0] addr;
    logic [4:0]  rd;
    logic        we_;
    logic        x_busy, x_en;
    logic [3:0]  x_exp;
    logic [31:0] x_out, x_pc;
    logic [4:0]  x_rd;
    logic        x_we_;
  } vec_t;

  function automatic vec_t mk(logic fl, logic st, logic en, logic [3:0] exp, logic [3:0] op,
                              logic [31:0] addr, logic [4:0] rd, logic we_, logic x_busy,
                              logic x_en, logic [3:0] x_exp, logic [31:0] x_out,
                              logic [31:0] x_pc, logic [4:0] x_rd, logic x_we_);
    vec_t v;
    v.flush = fl; v.stall = st; v.en = en; v.exp = exp; v.op = op; v.addr = addr;
    v.rd = rd; v.we_ = we_; v.x_busy = x_busy; v.x_en = x_en; v.x_exp = x_exp;
    v.x_out = x_out; v.x_pc = x_pc; v.x_rd = x_rd; v.x_we_ = x_we_;
    return v;
  endfunction

  // One memory instruction, fixed wait count, checks bus and retire values
  task automatic run_mem(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int waits, input logic [3:0] x_be,
                         input logic [31:0] x_wd, input logic [31:0] x_out, input logic x_we_);
    ex_en = 1'b1; ex_exp_code = 4'h0; ex_mem_op = op; ex_out = addr; ex_mem_wr_data = wd;
    ex_rd_addr = 5'd10; ex_gpr_we_ = 1'b0; ex_pc = 32'h2000;
    #1 chk("busy_detect", 32'(busy), 32'd1);
    edge1();
    chk("rq_rise", 32'(dbus_rq), 32'd1);
    chk("dbus_addr", dbus_addr, {addr[31:2], 2'b00});
    chk("dbus_be", 32'(dbus_be), 32'(x_be));
    chk("dbus_we", 32'(dbus_we), 32'(op >= STW));
    if (op >= STW) chk("dbus_wr_data", dbus_wr_data, x_wd);
    for (int i = 0; i < waits; i++) begin
      dbus_rdy = 1'b0;
      #1 chk("busy_wait", 32'(busy), 32'd1);
      edge1();
      chk("rq_hold", 32'(dbus_rq), 32'd1);
      chk("addr_hold", dbus_addr, {addr[31:2], 2'b00});
    end
    dbus_rdy = 1'b1; dbus_rd_data = rdata;
    #1 chk("busy_rdy", 32'(busy), 32'd0);
    edge1();
    dbus_rdy = 1'b0; dbus_rd_data = 32'hDEAD_0000;
    chk("rq_fall", 32'(dbus_rq), 32'd0);
    chk("ret_en", 32'(mem_en), 32'd1);
    chk("ret_out", mem_out, x_out);
    chk("ret_we_", 32'(mem_gpr_we_), 32'(x_we_));
    chk("ret_rd", 32'(mem_rd_addr), 32'd10);
    ex_en = 1'b0;
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = mk(0,0,1,4'h0,NOP, 32'hDEADBEEF,5'd5,0, 0,1,4'h0,32'hDEADBEEF,32'h1000,5'd5,0);
    tbl[1]  = mk(0,0,0,4'h0,NOP, 32'h11,      5'd3,0, 0,0,4'h0,32'h11,      32'h1004,5'd3,0);
    tbl[2]  = mk(0,0,1,4'h0,LDW, 32'h41,      5'd7,0, 0,1,MIS, 32'h41,      32'h1008,5'd7,1);
    tbl[3]  = mk(0,0,1,4'h0,LDH, 32'h43,      5'd8,0, 0,1,MIS, 32'h43,      32'h100C,5'd8,1);
    tbl[4]  = mk(0,0,1,4'h0,LDHU,32'h1,       5'd2,0, 0,1,MIS, 32'h1,       32'h1010,5'd2,1);
    tbl[5]  = mk(0,0,1,4'h0,STW, 32'h2,       5'd0,1, 0,1,MIS, 32'h2,       32'h1014,5'd0,1);
    tbl[6]  = mk(0,0,1,4'h0,STH, 32'h23,      5'd4,0, 0,1,MIS, 32'h23,      32'h1018,5'd4,1);
    tbl[7]  = mk(0,0,1,ILL, LDW, 32'h41,      5'd9,0, 0,1,ILL, 32'h41,      32'h101C,5'd9,0);
    tbl[8]  = mk(0,1,1,4'h0,NOP, 32'h77,      5'd1,0, 0,1,ILL, 32'h41,      32'h101C,5'd9,0);
    tbl[9]  = mk(1,0,1,4'h0,NOP, 32'h55,      5'd6,0, 0,0,4'h0,32'h0,       32'h0,   5'd0,1);
    tbl[10] = mk(0,0,1,ILL, LDB, 32'h7,       5'd11,0,0,1,ILL, 32'h7,       32'h1028,5'd11,0);
    tbl[11] = mk(0,0,0,4'h0,LDBU,32'h3,       5'd12,0,0,0,4'h0,32'h3,       32'h102C,5'd12,0);

    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_en = 1'b0; ex_exp_code = 4'h0;
    ex_mem_op = NOP; ex_pc = 32'h0; ex_mem_wr_data = 32'h0; ex_out = 32'h0;
    ex_rd_addr = 5'd0; ex_gpr_we_ = 1'b1; ex_hart_st = 2'd0;
    dbus_rdy = 1'b0; dbus_rd_data = 32'h0;
    edge1(); edge1();
    reset = 1'b0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rq", 32'(dbus_rq), 32'd0);
    chk("rst_we", 32'(dbus_we), 32'd0);
    chk("rst_be", 32'(dbus_be), 32'd0);
    chk("rst_addr", dbus_addr, 32'h0);
    chk("rst_wdata", dbus_wr_data, 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_we_", 32'(mem_gpr_we_), 32'd1);
    chk("rst_mem_out", mem_out, 32'h0);

    for (int i = 0; i < 12; i++) begin
      flush = tbl[i].flush; stall = tbl[i].stall; ex_en = tbl[i].en;
      ex_exp_code = tbl[i].exp; ex_mem_op = tbl[i].op; ex_out = tbl[i].addr;
      ex_rd_addr = tbl[i].rd; ex_gpr_we_ = tbl[i].we_; ex_pc = 32'h1000 + 32'(4 * i);
      ex_hart_st = 2'(i);
      #1 chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].x_busy));
      edge1();
      chk($sformatf("v%0d_rq", i), 32'(dbus_rq), 32'd0);
      chk($sformatf("v%0d_en", i), 32'(mem_en), 32'(tbl[i].x_en));
      chk($sformatf("v%0d_exp", i), 32'(mem_exp_code), 32'(tbl[i].x_exp));
      chk($sformatf("v%0d_out", i), mem_out, tbl[i].x_out);
      chk($sformatf("v%0d_pc", i), mem_pc, tbl[i].x_pc);
      chk($sformatf("v%0d_rd", i), 32'(mem_rd_addr), 32'(tbl[i].x_rd));
      chk($sformatf("v%0d_we_", i), 32'(mem_gpr_we_), 32'(tbl[i].x_we_));
    end
    flush = 1'b0; stall = 1'b0; ex_en = 1'b0; ex_exp_code = 4'h0; ex_hart_st = 2'd0;

    run_mem(LDB,  32'h103, 32'h0, 32'h8000_0000, 2, 4'b1000, 32'h0, 32'hFFFF_FF80, 1'b0);
    run_mem(LDBU, 32'h103, 32'h0, 32'h8000_0000, 2, 4'b1000, 32'h0, 32'h0000_0080, 1'b0);
    run_mem(STH,  32'h22, 32'h1234_ABCD, 32'h0, 1, 4'b1100, 32'hABCD_ABCD, 32'h22, 1'b1);
    run_mem(STB,  32'h101, 32'h0000_005A, 32'h0, 0, 4'b0010, 32'h5A5A_5A5A, 32'h101, 1'b1);
    run_mem(LDH,  32'h102, 32'h0, 32'h8001_7FFF, 0, 4'b1100, 32'h0, 32'hFFFF_8001, 1'b0);
    run_mem(LDHU, 32'h102, 32'h0, 32'h8001_7FFF, 1, 4'b1100, 32'h0, 32'h0000_8001, 1'b0);
    run_mem(LDW,  32'h0, 32'h0, 32'hCAFE_F00D, 0, 4'b1111, 32'h0, 32'hCAFE_F00D, 1'b0);
    run_mem(LDW,  32'h4, 32'h0, 32'h0BAD_BEEF, 0, 4'b1111, 32'h0, 32'h0BAD_BEEF, 1'b0);

    // flush one cycle into BUSY: transaction completes, bubble retires
    ex_en = 1'b1; ex_mem_op = LDW; ex_out = 32'h8; ex_rd_addr = 5'd10; ex_gpr_we_ = 1'b0;
    ex_pc = 32'h3000;
    edge1();
    flush = 1'b1;
    edge1();
    flush = 1'b0;
    chk("fl_rq_held", 32'(dbus_rq), 32'd1);
    edge1();
    chk("fl_rq_held2", 32'(dbus_rq), 32'd1);
    dbus_rdy = 1'b1; dbus_rd_data = 32'h1111_2222;
    #1 chk("fl_busy_rdy", 32'(busy), 32'd0);
    edge1();
    dbus_rdy = 1'b0;
    chk("fl_rq_fall", 32'(dbus_rq), 32'd0);
    chk("fl_bubble_en", 32'(mem_en), 32'd0);
    chk("fl_bubble_out", mem_out, 32'h0);
    chk("fl_bubble_pc", mem_pc, 32'h0);
    ex_en = 1'b0;
    run_mem(LDW, 32'hC, 32'h0, 32'h5555_AAAA, 1, 4'b1111, 32'h0, 32'h5555_AAAA, 1'b0);

    // reset while BUSY
    ex_en = 1'b1; ex_mem_op = STW; ex_out = 32'h10; ex_mem_wr_data = 32'h7777_8888;
    edge1();
    chk("rb_rq", 32'(dbus_rq), 32'd1);
    reset = 1'b1;
    edge1();
    reset = 1'b0; ex_en = 1'b0;
    chk("rb_rq0", 32'(dbus_rq), 32'd0);
    chk("rb_addr0", dbus_addr, 32'h0);
    chk("rb_be0", 32'(dbus_be), 32'd0);
    chk("rb_we0", 32'(dbus_we), 32'd0);
    chk("rb_wd0", dbus_wr_data, 32'h0);
    chk("rb_mem_en", 32'(mem_en), 32'd0);
    chk("rb_mem_we_", 32'(mem_gpr_we_), 32'd1);
    dbus_rdy = 1'b1;
    #1 chk("rb_busy", 32'(busy), 32'd0);
    edge1();
    dbus_rdy = 1'b0;
    chk("rb_idle_rdy_ignored", 32'(dbus_rq), 32'd0);

    // dbus_rdy under external stall: result buffered until stall drops
    ex_en = 1'b1; ex_mem_op = LDB; ex_out = 32'h101; ex_rd_addr = 5'd10; ex_gpr_we_ = 1'b0;
    edge1();
    stall = 1'b1; dbus_rdy = 1'b1; dbus_rd_data = 32'h0000_FE00;
    edge1();
    dbus_rdy = 1'b0; dbus_rd_data = 32'h1234_5678;
    chk("st_rq_fall", 32'(dbus_rq), 32'd0);
    chk("st_busy_hold", 32'(busy), 32'd1);
    edge1();
    chk("st_busy_hold2", 32'(busy), 32'd1);
    stall = 1'b0;
    #1 chk("st_busy_release", 32'(busy), 32'd0);
    edge1();
    chk("st_out", mem_out, 32'hFFFF_FFFE);
    chk("st_en", 32'(mem_en), 32'd1);
    ex_en = 1'b0;
    edge1();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

MEM-stage controller sitting on the far side of the EX/MEM pipeline register: it consumes the `ex_*` fields, performs loads and stores on the data bus with a request/ready handshake, and drives the MEM/WB pipeline register. It handles byte-lane steering, sign/zero extension and alignment checking. While a bus access is outstanding it asserts `busy` so the hart controller stalls the upstream stages.

## Interface
Parameters: none. Widths come from `common_defines.v`, `base_core_defines.v` and `hart_ctrl.h`; word = 32 bits.

- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `stall` input 1: hart-controller stall; freezes the MEM/WB register.
- `flush` input 1: kills the instruction currently in MEM.
- `ex_en`, `ex_exp_code`, `ex_pc`, `ex_mem_op`, `ex_mem_wr_data`, `ex_out`, `ex_rd_addr`, `ex_gpr_we_`, `ex_hart_st` input: EX/MEM register fields. `ex_out` is the effective address for memory ops.
- `dbus_rq` output 1: bus request, registered.
- `dbus_we` output 1: 1 = write.
- `dbus_addr` output 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dbus_be` output 4: byte enables; bit i = byte lane i (little-endian).
- `dbus_wr_data` output 32: lane-replicated store data.
- `dbus_rdy` input 1: access complete; read data valid this cycle.
- `dbus_rd_data` input 32: read data.
- `busy` output 1: combinational stall request.
- `mem_en`, `mem_exp_code`, `mem_pc`, `mem_out`, `mem_rd_addr`, `mem_gpr_we_`, `mem_hart_st` output: MEM/WB register fields.

## Operation
- **Access needed.** An access is needed when `ex_en`=1, `ex_exp_code`=`EXP_NO_EXP`, `ex_mem_op`≠`MEM_OP_NOP`, and the address is aligned.
- **Alignment.** LDW/STW require `addr[1:0]`=0. LDH/LDHU/STH require `addr[0]`=0. Byte ops are always aligned.
- **Misaligned access.** No bus request. The MEM/WB register loads `mem_exp_code`=`EXP_MISALIGN` and `mem_gpr_we_`=`DISABLE_`; all other fields pass through.
- **FSM states.**
  - IDLE: when an access is needed, latch `dbus_addr`, `dbus_be`, `dbus_wr_data` and `dbus_we`; set `dbus_rq`=1; go to BUSY.
  - BUSY: hold every `dbus_*` output stable. On `dbus_rdy`=1, clear `dbus_rq` and return to IDLE.
- **busy.** `busy` = (IDLE ∧ access needed) ∨ (BUSY ∧ ¬`dbus_rdy`).
- **Stores.**
  - STB: be = 1<<addr[1:0]; data = byte replicated into all 4 lanes.
  - STH: be = 0011 (addr[1]=0) or 1100 (addr[1]=1); data = halfword replicated.
  - STW: be = 1111.
- **Loads.** Select the lane from the latched `addr[1:0]`. LDB/LDH sign-extend; LDBU/LDHU zero-extend. The formatted value drives `mem_out` from `dbus_rd_data` in the `dbus_rdy` cycle.
- **Other fields.** Non-memory ops and excepted instructions: `mem_out`=`ex_out`.
- **MEM/WB register update priority:**
  1. `reset`: clear.
  2. `stall`: hold.
  3. `flush`, `busy`, or kill flag: load a bubble.
  4. Otherwise: load the fields.
- **Bubble / clear values.** `mem_en`=`DISABLE`, `mem_exp_code`=`EXP_NO_EXP`, `mem_gpr_we_`=`DISABLE_`, `mem_rd_addr`=0, `mem_out`=0, `mem_pc`=0, `mem_hart_st`=0.
- **Flush during BUSY.** The bus transaction is never abandoned. Set the kill flag, keep waiting for `dbus_rdy`, then write a bubble and clear the kill flag. Flush in IDLE with an access needed: no request is issued.
- **Stores write no register.** `mem_gpr_we_` = `DISABLE_`.

## Timing
- **Reset values.** State IDLE, kill flag 0, `dbus_rq`=0, `dbus_we`=0, `dbus_be`=0, `dbus_addr`=0, `dbus_wr_data`=0, MEM/WB fields at clear values. `busy` is 0 after reset provided `ex_en`=0.
- **Latency.** A memory op occupies MEM for a minimum of 2 cycles: the IDLE detect cycle plus a BUSY cycle with `dbus_rdy`. Add one cycle per wait cycle of `dbus_rdy`=0. Non-memory ops and misaligned ops take 1 cycle.
- **Bus handshake.**
  - `dbus_rq` rises on the clock edge after detect.
  - Bus outputs stay constant until the edge on which `dbus_rdy`=1 is sampled.
  - `dbus_rdy` is ignored in IDLE.
- **Retire edge.** On the `dbus_rdy` edge, `busy`=0, so the MEM/WB register loads the result and upstream advances together. The next `ex_*` instruction is evaluated in IDLE in the following cycle; back-to-back accesses are allowed.
- **External stall.** External `stall`=1 in BUSY does not block the bus. If `dbus_rdy` arrives while `stall`=1, buffer the formatted result. Present it on the first edge with `stall`=0, and keep `busy`=1 until then.
- **Mid-access reset.** Reset during BUSY returns to IDLE and drops `dbus_rq` on the same edge.

## Test plan
- **Aligned LDB.** LDB at addr 0x103, `dbus_rd_data`=0x80_00_00_00, `dbus_rdy` after 2 wait cycles -> `dbus_be`=1000, `dbus_addr`=0x100, `busy` high 3 cycles, `mem_out`=0xFFFFFF80. Repeat with LDBU -> `mem_out`=0x00000080.
- **STH.** STH addr 0x22, `ex_mem_wr_data`=0x1234ABCD -> `dbus_we`=1, `dbus_be`=1100, `dbus_wr_data`=0xABCDABCD, `mem_gpr_we_`=`DISABLE_`.
- **Misaligned LDW.** LDW addr 0x41 -> `dbus_rq` never asserted, `busy`=0, `mem_exp_code`=`EXP_MISALIGN`, `mem_gpr_we_`=`DISABLE_`.
- **Flush during BUSY.** Flush pulse 1 cycle into BUSY, `dbus_rdy` 3 cycles later -> `dbus_rq` held until `dbus_rdy`, then a bubble with `mem_en`=0; the next instruction proceeds normally.
- **Reset mid-access.** Reset asserted in BUSY -> next cycle state IDLE, `dbus_rq`=0, all outputs at reset values.
- **Back-to-back loads.** Back-to-back LDW 0x0, LDW 0x4 with zero-wait `dbus_rdy` -> each retires after 2 cycles, with `dbus_rq` deasserted for 1 cycle between them.
